// File: rtl/fetch_queue_pkg.sv
// Shared types for the PC-tagged fetch queue: fetch exception codes,
// branch-prediction info and the queue entry record.
package fetch_queue_pkg;

    localparam int FQ_XLEN      = 32;
    localparam int FQ_DEPTH_DEF = 4;

    typedef enum logic [3:0] {
        NO_EXCEPTION          = 4'd0,
        INSTR_ADDR_MISALIGNED = 4'd1,
        INSTR_ACCESS_FAULT    = 4'd2,
        ILLEGAL_INSTRUCTION   = 4'd3,
        INSTR_PAGE_FAULT      = 4'd4
    } exc_type_e;

    typedef struct packed {
        logic               taken;
        logic [FQ_XLEN-1:0] pc;
    } predict_info_t;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] inst;
        logic               is_comp;
        exc_type_e          exc;
        predict_info_t      spec;
    } fq_entry_t;

    // An entry carrying any fetch exception fences further enqueues.
    function automatic logic fq_is_exc(input exc_type_e exc);
        return (exc != NO_EXCEPTION);
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Circular register array for the fetch queue: one synchronous write port
// and one combinational read port.
module fq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_r [DEPTH];

    // Entry registers; cleared on reset so the head never shows X.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_r[wr_idx_i] <= wr_data_i;
        end
    end

    // Head read straight from the array.
    always_comb begin
        rd_data_o = mem_r[rd_idx_i];
    end

endmodule

// File: rtl/fetch_queue.sv
// PC-tagged instruction queue between fetch and decode with throttle hint,
// exception fence and single-cycle flush. Optional FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH     = FQ_DEPTH_DEF,
    parameter int AF_MARGIN = 1,
    parameter int XLEN      = FQ_XLEN
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   enq_valid_i,
    output logic                   enq_ready_o,
    input  logic [XLEN-1:0]        enq_pc_i,
    input  logic [XLEN-1:0]        enq_inst_i,
    input  logic                   enq_is_comp_i,
    input  exc_type_e              enq_exc_i,
    input  predict_info_t          enq_spec_i,
    output logic                   deq_valid_o,
    input  logic                   deq_ready_i,
    output logic [XLEN-1:0]        deq_pc_o,
    output logic [XLEN-1:0]        deq_inst_o,
    output logic                   deq_is_comp_o,
    output exc_type_e              deq_exc_o,
    output predict_info_t          deq_spec_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   almost_full_o,
    output logic                   fenced_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int EW = $bits(fq_entry_t);
    localparam logic [PW-1:0] AF_TH_C  = PW'(DEPTH - AF_MARGIN);
    localparam logic [PW-1:0] PTR_ONE_C = PW'(1);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic          fenced_r;
    logic          run_r;

    logic          empty_s;
    logic          full_s;
    logic [PW-1:0] count_s;
    logic          enq_fire_s;
    logic          deq_fire_s;
    logic          wr_en_s;
    logic          rd_adv_s;
    fq_entry_t     enq_entry_s;
    fq_entry_t     head_entry_s;
    logic [EW-1:0] rd_data_s;

    // Pack the incoming fetch fields into one entry.
    always_comb begin
        enq_entry_s         = '0;
        enq_entry_s.pc      = enq_pc_i;
        enq_entry_s.inst    = enq_inst_i;
        enq_entry_s.is_comp = enq_is_comp_i;
        enq_entry_s.exc     = enq_exc_i;
        enq_entry_s.spec    = enq_spec_i;
    end

    // Occupancy: wrap bit distinguishes full from empty at equal indices.
    always_comb begin
        empty_s       = (wr_ptr_r == rd_ptr_r);
        full_s        = (wr_ptr_r[IW-1:0] == rd_ptr_r[IW-1:0]) &&
                        (wr_ptr_r[IW] != rd_ptr_r[IW]);
        count_s       = wr_ptr_r - rd_ptr_r;
        count_o       = count_s;
        almost_full_o = (count_s >= AF_TH_C);
        fenced_o      = fenced_r;
        enq_ready_o   = run_r & ~full_s & ~fenced_r & ~flush_i;
        enq_fire_s    = enq_valid_i & enq_ready_o;
    end

    // Head selection and pointer-advance decisions.
    always_comb begin
        head_entry_s = fq_entry_t'(rd_data_s);
        deq_valid_o  = ~empty_s & ~flush_i;
        wr_en_s      = enq_fire_s;
        rd_adv_s     = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (empty_s && !flush_i && run_r) begin
            // Empty queue: present the offered entry directly; store it only
            // if decode does not take it this cycle.
            head_entry_s = enq_entry_s;
            deq_valid_o  = enq_valid_i & ~fenced_r;
            wr_en_s      = enq_fire_s & ~deq_ready_i;
            rd_adv_s     = 1'b0;
        end else begin
            rd_adv_s = deq_valid_o & deq_ready_i;
        end
`else
        rd_adv_s = deq_valid_o & deq_ready_i;
`endif
        deq_fire_s = deq_valid_o & deq_ready_i;
    end

    // Head fields on the decode side.
    always_comb begin
        deq_pc_o      = head_entry_s.pc;
        deq_inst_o    = head_entry_s.inst;
        deq_is_comp_o = head_entry_s.is_comp;
        deq_exc_o     = head_entry_s.exc;
        deq_spec_o    = head_entry_s.spec;
    end

    // Pointers, fence and run flag; flush overrides any concurrent transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fenced_r <= 1'b0;
            run_r    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fenced_r <= 1'b0;
            run_r    <= 1'b1;
        end else begin
            run_r <= 1'b1;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            if (enq_fire_s && fq_is_exc(enq_exc_i)) begin
                fenced_r <= 1'b1;
            end
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_storage (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (wr_en_s),
        .wr_idx_i  (wr_ptr_r[IW-1:0]),
        .wr_data_i (enq_entry_s),
        .rd_idx_i  (rd_ptr_r[IW-1:0]),
        .rd_data_o (rd_data_s)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AFM   = 1;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          enq_valid_i = 1'b0;
    logic          enq_ready_o;
    logic [31:0]   enq_pc_i = '0;
    logic [31:0]   enq_inst_i = '0;
    logic          enq_is_comp_i = 1'b0;
    exc_type_e     enq_exc_i = NO_EXCEPTION;
    predict_info_t enq_spec_i = '0;
    logic          deq_valid_o;
    logic          deq_ready_i = 1'b0;
    logic [31:0]   deq_pc_o;
    logic [31:0]   deq_inst_o;
    logic          deq_is_comp_o;
    exc_type_e     deq_exc_o;
    predict_info_t deq_spec_o;
    logic [2:0]    count_o;
    logic          almost_full_o;
    logic          fenced_o;

    fetch_queue #(.DEPTH(DEPTH), .AF_MARGIN(AFM), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_pc_i(enq_pc_i), .enq_inst_i(enq_inst_i),
        .enq_is_comp_i(enq_is_comp_i), .enq_exc_i(enq_exc_i),
        .enq_spec_i(enq_spec_i),
        .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
        .deq_pc_o(deq_pc_o), .deq_inst_o(deq_inst_o),
        .deq_is_comp_o(deq_is_comp_o), .deq_exc_o(deq_exc_o),
        .deq_spec_o(deq_spec_o),
        .count_o(count_o), .almost_full_o(almost_full_o), .fenced_o(fenced_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        ev;
        logic [31:0] pc;
        logic        dr;
        int          e_cnt;
        logic        e_rdy;
        logic        e_dv;
        logic        e_af;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic fq_entry_t mk_entry(input logic [31:0] pc, input exc_type_e ex);
        fq_entry_t e;
        e.pc         = pc;
        e.inst       = pc ^ 32'h1357_9BDF;
        e.is_comp    = pc[1];
        e.exc        = ex;
        e.spec.taken = pc[2];
        e.spec.pc    = pc + 32'h0000_0040;
        return e;
    endfunction

    task automatic drive(input logic fl, input logic ev, input logic [31:0] pc,
                         input exc_type_e ex, input logic dr);
        fq_entry_t e;
        e             = mk_entry(pc, ex);
        flush_i       = fl;
        enq_valid_i   = ev;
        enq_pc_i      = e.pc;
        enq_inst_i    = e.inst;
        enq_is_comp_i = e.is_comp;
        enq_exc_i     = e.exc;
        enq_spec_i    = e.spec;
        deq_ready_i   = dr;
    endtask

    // Reference model state: plain FIFO of entries plus fence/run flags.
    fq_entry_t mq[$];
    bit        m_fen;
    bit        m_run;

    initial begin
        logic [31:0] pc;
        logic        ev, fl, dr, stall, e_rdy, e_dv, byp_fire;
        exc_type_e   ex;
        fq_entry_t   head, cur;

        vecs[0] = '{1'b1, 32'h8000_0000, 1'b0, 0, 1'b1, BYP,  1'b0, 32'h8000_0000};
        vecs[1] = '{1'b1, 32'h8000_0004, 1'b0, 1, 1'b1, 1'b1, 1'b0, 32'h8000_0000};
        vecs[2] = '{1'b1, 32'h8000_0006, 1'b0, 2, 1'b1, 1'b1, 1'b0, 32'h8000_0000};
        vecs[3] = '{1'b1, 32'h8000_000A, 1'b0, 3, 1'b1, 1'b1, 1'b1, 32'h8000_0000};
        vecs[4] = '{1'b0, 32'h0000_0000, 1'b0, 4, 1'b0, 1'b1, 1'b1, 32'h8000_0000};
        vecs[5] = '{1'b0, 32'h0000_0000, 1'b1, 4, 1'b0, 1'b1, 1'b1, 32'h8000_0000};
        vecs[6] = '{1'b0, 32'h0000_0000, 1'b1, 3, 1'b1, 1'b1, 1'b1, 32'h8000_0004};
        vecs[7] = '{1'b0, 32'h0000_0000, 1'b1, 2, 1'b1, 1'b1, 1'b0, 32'h8000_0006};
        vecs[8] = '{1'b0, 32'h0000_0000, 1'b1, 1, 1'b1, 1'b1, 1'b0, 32'h8000_000A};
        vecs[9] = '{1'b0, 32'h0000_0000, 1'b0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};

        // Reset state, released between clock edges.
        drive(1'b0, 1'b0, 32'h0, NO_EXCEPTION, 1'b0);
        #3;
        chk("rst_dv", deq_valid_o, 1'b0);
        chk("rst_rdy", enq_ready_o, 1'b0);
        chk("rst_cnt", count_o, 0);
        chk("rst_af", almost_full_o, 1'b0);
        chk("rst_fen", fenced_o, 1'b0);
        #9 rst_ni = 1'b1;
        tick();
        chk("post_rst_rdy", enq_ready_o, 1'b1);

        // Fill then drain through the vector table.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, vecs[i].ev, vecs[i].pc, NO_EXCEPTION, vecs[i].dr);
            #2;
            chk($sformatf("tbl%0d_cnt", i), count_o, vecs[i].e_cnt);
            chk($sformatf("tbl%0d_rdy", i), enq_ready_o, vecs[i].e_rdy);
            chk($sformatf("tbl%0d_dv", i), deq_valid_o, vecs[i].e_dv);
            chk($sformatf("tbl%0d_af", i), almost_full_o, vecs[i].e_af);
            if (vecs[i].e_dv) chk($sformatf("tbl%0d_pc", i), deq_pc_o, vecs[i].e_pc);
            tick();
        end

        // Wrap: steady count 2 with simultaneous enqueue and dequeue.
        drive(1'b0, 1'b1, 32'h8000_1000, NO_EXCEPTION, 1'b0); tick();
        drive(1'b0, 1'b1, 32'h8000_1004, NO_EXCEPTION, 1'b0); tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 32'h8000_1000 + 32'(4 * (k + 2)), NO_EXCEPTION, 1'b1);
            #2;
            chk($sformatf("wrap%0d_cnt", k), count_o, 2);
            chk($sformatf("wrap%0d_pc", k), deq_pc_o, 32'h8000_1000 + 32'(4 * k));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, NO_EXCEPTION, 1'b1);
        #2 chk("wrap_tail0", deq_pc_o, 32'h8000_1028);
        tick();
        #2 chk("wrap_tail1", deq_pc_o, 32'h8000_102C);
        tick();
        #2 chk("wrap_empty", deq_valid_o, 1'b0);

        // Exception fence.
        drive(1'b0, 1'b1, 32'h8000_2000, NO_EXCEPTION, 1'b0); tick();
        drive(1'b0, 1'b1, 32'h8000_2004, ILLEGAL_INSTRUCTION, 1'b0);
        #2 chk("fen_pre_rdy", enq_ready_o, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, NO_EXCEPTION, 1'b0);
        #2;
        chk("fen_set", fenced_o, 1'b1);
        chk("fen_rdy", enq_ready_o, 1'b0);
        chk("fen_cnt", count_o, 2);
        deq_ready_i = 1'b1;
        #1 chk("fen_d1_pc", deq_pc_o, 32'h8000_2000);
        tick();
        #2;
        chk("fen_d2_pc", deq_pc_o, 32'h8000_2004);
        chk("fen_d2_exc", deq_exc_o, ILLEGAL_INSTRUCTION);
        tick();
        deq_ready_i = 1'b0;
        #2;
        chk("fen_drained", count_o, 0);
        chk("fen_hold", fenced_o, 1'b1);
        flush_i = 1'b1;
        #1;
        chk("fen_fl_dv", deq_valid_o, 1'b0);
        chk("fen_fl_rdy", enq_ready_o, 1'b0);
        tick();
        flush_i = 1'b0;
        #2;
        chk("fen_clr", fenced_o, 1'b0);
        chk("fen_clr_rdy", enq_ready_o, 1'b1);
        chk("fen_clr_cnt", count_o, 0);

        // Flush against concurrent enqueue and dequeue at count 3.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 32'h8000_3000 + 32'(4 * k), NO_EXCEPTION, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h8000_300C, NO_EXCEPTION, 1'b1);
        #2;
        chk("fl_cnt3", count_o, 3);
        chk("fl_dv", deq_valid_o, 1'b0);
        chk("fl_rdy", enq_ready_o, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, NO_EXCEPTION, 1'b0);
        #2;
        chk("fl_cnt0", count_o, 0);
        chk("fl_dv_after", deq_valid_o, 1'b0);

        // Asynchronous reset between edges.
        drive(1'b0, 1'b1, 32'h8000_4000, NO_EXCEPTION, 1'b0); tick();
        drive(1'b0, 1'b1, 32'h8000_4004, NO_EXCEPTION, 1'b0); tick();
        drive(1'b0, 1'b0, 32'h0, NO_EXCEPTION, 1'b0);
        #2 chk("ar_cnt2", count_o, 2);
        rst_ni = 1'b0;
        #1;
        chk("ar_dv", deq_valid_o, 1'b0);
        chk("ar_cnt", count_o, 0);
        chk("ar_rdy", enq_ready_o, 1'b0);
        #2 rst_ni = 1'b1;
        tick();
        chk("ar_rdy_back", enq_ready_o, 1'b1);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Bypass on an empty queue.
        drive(1'b0, 1'b1, 32'h8000_0100, NO_EXCEPTION, 1'b1);
        #2;
        chk("byp_dv", deq_valid_o, 1'b1);
        chk("byp_pc", deq_pc_o, 32'h8000_0100);
        chk("byp_cnt", count_o, 0);
        tick();
        drive(1'b0, 1'b0, 32'h0, NO_EXCEPTION, 1'b0);
        #2;
        chk("byp_cnt_after", count_o, 0);
        chk("byp_dv_after", deq_valid_o, 1'b0);
`endif

        // Randomized traffic against the reference model, from a clean flush.
        drive(1'b1, 1'b0, 32'h0, NO_EXCEPTION, 1'b0);
        tick();
        mq.delete();
        m_fen = 1'b0;
        m_run = 1'b1;
        stall = 1'b0;
        ev = 1'b0; pc = '0; ex = NO_EXCEPTION;
        for (int i = 0; i < 400; i++) begin
            fl = ($urandom_range(0, 19) == 0);
            dr = ($urandom_range(0, 2) != 0);
            if (!stall) begin
                ev = ($urandom_range(0, 2) != 0);
                pc = $urandom() & 32'hFFFF_FFFE;
                ex = ($urandom_range(0, 24) == 0) ? ILLEGAL_INSTRUCTION :
                     (($urandom_range(0, 39) == 0) ? INSTR_PAGE_FAULT : NO_EXCEPTION);
            end
            drive(fl, ev, pc, ex, dr);
            cur   = mk_entry(pc, ex);
            e_rdy = m_run && (mq.size() < DEPTH) && !m_fen && !fl;
            e_dv  = !fl && ((mq.size() > 0) || (BYP && ev && !m_fen && m_run));
            head  = (mq.size() > 0) ? mq[0] : cur;
            #2;
            chk("rnd_rdy", enq_ready_o, e_rdy);
            chk("rnd_dv", deq_valid_o, e_dv);
            chk("rnd_cnt", count_o, mq.size());
            chk("rnd_af", almost_full_o, mq.size() >= DEPTH - AFM);
            chk("rnd_fen", fenced_o, m_fen);
            if (e_dv) begin
                chk("rnd_pc", deq_pc_o, head.pc);
                chk("rnd_inst", deq_inst_o, head.inst);
                chk("rnd_comp", deq_is_comp_o, head.is_comp);
                chk("rnd_exc", deq_exc_o, head.exc);
                chk("rnd_spec", deq_spec_o, head.spec);
            end
            if (fl) begin
                mq.delete();
                m_fen = 1'b0;
            end else begin
                byp_fire = e_dv && dr && (mq.size() == 0);
                if (e_dv && dr && !byp_fire) void'(mq.pop_front());
                if (ev && e_rdy && !byp_fire) mq.push_back(cur);
                if (ev && e_rdy && (ex != NO_EXCEPTION)) m_fen = 1'b1;
            end
            stall = ev && !e_rdy && !fl;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised, PC-tagged instruction queue between the fetch stage (align buffer plus compressed decoder) and decode.
- Decouples I-cache and align-buffer latency from decode stalls.
- Each entry carries the PC, the expanded instruction, the compressed flag, the fetch exception and the branch-prediction result.
- Adds occupancy-based fetch throttling, an exception fence and single-cycle flush; the current single-slot fetch path has none of these.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- AF_MARGIN, 1, almost_full_o asserts when count ≥ DEPTH-AF_MARGIN; range 0..DEPTH-1.
- XLEN, 32, PC and instruction width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush or redirect; empties the queue
- enq_valid_i  in  1  fetch offers an entry
- enq_ready_o  out  1  queue accepts an entry
- enq_pc_i  in  XLEN  instruction PC
- enq_inst_i  in  XLEN  expanded 32-bit instruction
- enq_is_comp_i  in  1  original instruction was compressed
- enq_exc_i  in  exc_type_e  fetch exception
- enq_spec_i  in  predict_info_t  prediction (taken, pc)
- deq_valid_o  out  1  head entry valid
- deq_ready_i  in  1  decode consumes the head
- deq_pc_o / deq_inst_o / deq_is_comp_o / deq_exc_o / deq_spec_o  out  per field  head entry fields
- count_o  out  $clog2(DEPTH)+1  occupancy
- almost_full_o  out  1  throttle hint to the PC-enable logic
- fenced_o  out  1  an exception entry is in flight; enqueue is blocked

Behaviour:
- Reset (async, rst_ni=0):
  - rd_ptr=wr_ptr=0, count_o=0, fenced=0.
  - deq_valid_o=0, enq_ready_o=0 while in reset; enq_ready_o=1 from the first edge after release.
  - almost_full_o=0.
  - Data fields of deq_* are don't-care while deq_valid_o=0.
- Storage and pointers:
  - Circular register array.
  - Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal. full = indices equal and wrap bits differ.
- Handshakes:
  - enq fire = enq_valid_i & enq_ready_o.
  - deq fire = deq_valid_o & deq_ready_i.
  - enq_ready_o = !full & !fenced & !flush_i.
  - enq_ready_o does not depend on deq_ready_i, so there is no combinational path and no push-through when full.
- Latency:
  - Entry visible on deq_* the cycle after enq fire (latency 1), unless the optional bypass is compiled in.
  - Head outputs are driven directly from storage[rd_ptr]; no extra register.
- Simultaneous enq and deq fire (non-full, non-empty): both pointers advance and count is unchanged.
- Exception fence:
  - Enqueueing an entry with enq_exc_i ≠ NO_EXCEPTION sets fenced on the next edge.
  - While fenced, enq_ready_o=0; entries already queued still drain.
  - fenced clears only on flush_i.
- Flush:
  - flush_i=1 forces deq_valid_o=0 and enq_ready_o=0 in the same cycle.
  - Next edge: both pointers reset to 0, count 0, fenced 0.
  - Flush has priority over any concurrent enq or deq.
- Count: count_o = wr_ptr - rd_ptr, computed modulo 2^(ptr width).
- Almost full: almost_full_o = (count_o ≥ DEPTH-AF_MARGIN). With AF_MARGIN=0 it equals full.
- Protocol rules:
  - Once enq_valid_i=1 with enq_ready_o=0, the upstream source keeps its inputs stable.
  - Once deq_valid_o=1, the head fields stay stable until deq fire or flush.
- Pointer wrap: an index of DEPTH-1 increments to 0 and toggles the wrap bit.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- With the macro, when the queue is empty and flush_i=0, the enq_* inputs drive deq_* combinationally:
  - deq_valid_o = enq_valid_i & !fenced.
  - If deq fires in that cycle, the entry is not written.
  - If deq does not fire, the entry is written normally.
  - The fence rule still applies to a bypassed exception entry.
- Without the macro, latency is always 1 and deq_* come purely from storage.

Decomposition:
- ceres_param gains:
  - fq_entry_t struct {pc, inst, is_comp, exc, spec}.
  - FQ_DEPTH_DEF=4.
- Use the existing exc_type_e and predict_info_t.
- One sub-module, fq_storage: the register array with write port (en, idx, data) and combinational read port (idx).
- Pointer, fence and flush control stays in fetch_queue.

Test Plan:
- Fill/drain, DEPTH=4, deq_ready_i=0: enqueue PCs 0x8000_0000, 0x8000_0004, 0x8000_0006, 0x8000_000A.
  - Expect count_o 1→4, enq_ready_o=0 at 4, almost_full_o=1 at count 3.
  - Then deq_ready_i=1: outputs in the same order, count back to 0, deq_valid_o=0.
- Wrap: 10 consecutive enqueue and dequeue pairs with simultaneous fire at count 2.
  - Expect count_o held at 2 and PC order preserved across the pointer wrap.
- Fence: enqueue entry 2 with exc=ILLEGAL_INSTRUCTION.
  - Expect fenced_o=1 next cycle and enq_ready_o=0.
  - Entries 1–2 still dequeue.
  - flush_i=1 for one cycle → count_o=0, fenced_o=0, enq_ready_o=1.
- Flush with concurrent enq and deq at count 3: that cycle deq_valid_o=0; next cycle count_o=0 and the offered entry is dropped.
- Async reset mid-operation: at count 2, pulse rst_ni low between edges.
  - Expect deq_valid_o=0 and count_o=0 immediately, without waiting for a clock edge.
- Bypass (macro on, queue empty): enq_valid_i=1, pc 0x8000_0100, deq_ready_i=1.
  - Expect deq_valid_o=1 with that PC in the same cycle and count_o remaining 0.
